// File: rtl/fpu_fp80_to_uint64.sv
// fpu_fp80_to_uint64
//   Converts an 80-bit x87 extended-precision operand into a 64-bit unsigned
//   magnitude plus a separate sign bit, rounded according to the x87 RC field.
//   This sits in the FBSTP path ahead of the BCD encoder. A small FSM runs the
//   conversion over three cycles behind a start/done handshake.
//
// Ports
//   clk         in   1   clock, rising edge
//   reset       in   1   asynchronous, active-high
//   enable      in   1   start pulse, only sampled while idle
//   fp_in       in   80  {sign[79], exp[78:64], mant[63:0]}, explicit integer bit
//   round_mode  in   2   00 nearest-even, 01 down, 10 up, 11 truncate
//   uint_out    out  64  rounded magnitude
//   sign_out    out  1   operand sign, forced to 1 when invalid
//   invalid     out  1   NaN / Inf / unnormal / magnitude >= 2^64
//   precision   out  1   result was inexact (0 when invalid)
//   busy        out  1   high from the accepting edge until done
//   done        out  1   one-cycle completion pulse

module fpu_fp80_to_uint64 #(
    parameter logic [63:0] INVALID_MAG = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [79:0] fp_in,
    input  logic [1:0]  round_mode,
    output logic [63:0] uint_out,
    output logic        sign_out,
    output logic        invalid,
    output logic        precision,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALIGN = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q;

    // Captured operand
    logic [79:0] fp_q;
    logic [1:0]  rm_q;

    // Alignment results
    logic [63:0] int_q, int_d;
    logic        rbit_q, rbit_d;
    logic        sticky_q, sticky_d;
    logic        inv_a_q, inv_a_d;

    // Rounding results
    logic [63:0] mag_q, mag_d;
    logic        inv_r_q, inv_r_d;
    logic        inex_q, inex_d;

    // Output registers
    logic [63:0] uint_q;
    logic        sign_q, invalid_q, precision_q, busy_q, done_q;

    // ------------------------------------------------------------------
    // Alignment: classify the operand and split it into integer part,
    // round bit and sticky bit.
    // ------------------------------------------------------------------
    logic [14:0]         exp_w;
    logic [63:0]         mant_w;
    logic signed [15:0]  e_w;
    logic [6:0]          shamt_w;
    logic [127:0]        shifted_w;

    always_comb begin
        exp_w     = fp_q[78:64];
        mant_w    = fp_q[63:0];
        e_w       = $signed({1'b0, exp_w}) - 16'sd16383;
        // For e in -1..63 the low 7 bits give 63-e exactly (0..64).
        shamt_w   = 7'd63 - e_w[6:0];
        shifted_w = '0;
        int_d     = '0;
        rbit_d    = 1'b0;
        sticky_d  = 1'b0;
        inv_a_d   = 1'b0;
        if (exp_w == 15'h7FFF) begin
            inv_a_d = 1'b1;
        end else if ((exp_w != 15'h0) && !mant_w[63]) begin
            inv_a_d = 1'b1;
        end else if (e_w > 16'sd63) begin
            inv_a_d = 1'b1;
        end else if (e_w >= -16'sd1) begin
            // Integer part lands in the upper half, fraction in the lower half;
            // e == -1 (shift by 64) leaves the whole mantissa as the fraction.
            shifted_w = {mant_w, 64'h0} >> shamt_w;
            int_d     = shifted_w[127:64];
            rbit_d    = shifted_w[63];
            sticky_d  = |shifted_w[62:0];
        end else begin
            // Zero, denormals and |x| < 0.5: everything is below the round bit.
            sticky_d = |mant_w;
        end
    end

    // ------------------------------------------------------------------
    // Rounding: choose the increment from RC and the sign, detect carry-out.
    // ------------------------------------------------------------------
    logic        inc_w;
    logic [64:0] sum_w;

    always_comb begin
        inex_d = rbit_q | sticky_q;
        inc_w  = 1'b0;
        case (rm_q)
            2'b00: inc_w = rbit_q & (sticky_q | int_q[0]);
            2'b01: inc_w = inex_d & fp_q[79];
            2'b10: inc_w = inex_d & ~fp_q[79];
            default: inc_w = 1'b0;
        endcase
        sum_w   = {1'b0, int_q} + {64'h0, inc_w};
        mag_d   = sum_w[63:0];
        inv_r_d = inv_a_q | sum_w[64];
    end

    // Datapath registers carry no reset; they are only consumed under FSM control.
    always_ff @(posedge clk) begin
        if ((state_q == S_IDLE) && enable) begin
            fp_q <= fp_in;
            rm_q <= round_mode;
        end
        if (state_q == S_ALIGN) begin
            int_q    <= int_d;
            rbit_q   <= rbit_d;
            sticky_q <= sticky_d;
            inv_a_q  <= inv_a_d;
        end
        if (state_q == S_ROUND) begin
            mag_q   <= mag_d;
            inv_r_q <= inv_r_d;
            inex_q  <= inex_d;
        end
    end

    // FSM with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            uint_q      <= '0;
            sign_q      <= 1'b0;
            invalid_q   <= 1'b0;
            precision_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        busy_q  <= 1'b1;
                        state_q <= S_ALIGN;
                    end
                end
                S_ALIGN: state_q <= S_ROUND;
                S_ROUND: state_q <= S_DONE;
                S_DONE: begin
                    if (inv_r_q) begin
                        uint_q      <= INVALID_MAG;
                        sign_q      <= 1'b1;
                        invalid_q   <= 1'b1;
                        precision_q <= 1'b0;
                    end else begin
                        uint_q      <= mag_q;
                        sign_q      <= fp_q[79];
                        invalid_q   <= 1'b0;
                        precision_q <= inex_q;
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign uint_out  = uint_q;
    assign sign_out  = sign_q;
    assign invalid   = invalid_q;
    assign precision = precision_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_fpu_fp80_to_uint64.sv
// tb_fpu_fp80_to_uint64
//   Directed vectors for the FP80 -> uint64 converter. Each accepted start
//   pushes its hand-computed result into a queue; a negedge monitor pops and
//   compares whenever done is seen, including the cycle it arrived on.

module tb_fpu_fp80_to_uint64;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [79:0] fp_in;
    logic [1:0]  round_mode;
    logic [63:0] uint_out;
    logic        sign_out;
    logic        invalid;
    logic        precision;
    logic        busy;
    logic        done;

    fpu_fp80_to_uint64 #(.INVALID_MAG(64'h0)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .fp_in      (fp_in),
        .round_mode (round_mode),
        .uint_out   (uint_out),
        .sign_out   (sign_out),
        .invalid    (invalid),
        .precision  (precision),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] mag;
        logic        sign;
        logic        inv;
        logic        prec;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   ncyc     = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: counts negedges and checks every completion against the queue.
    always @(negedge clk) begin
        exp_t e;
        ncyc++;
        if (!reset && done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_done: got done=1 at cycle %0d expected no completion", ncyc);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", 64'(ncyc), 64'(e.due));
                chk("uint_out",   uint_out,  e.mag);
                chk("sign_out",   {63'h0, sign_out},  {63'h0, e.sign});
                chk("invalid",    {63'h0, invalid},   {63'h0, e.inv});
                chk("precision",  {63'h0, precision}, {63'h0, e.prec});
                chk("busy_at_done", {63'h0, busy}, 64'h0);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Drive one start at the current point (just after a negedge) and drop
    // enable after the accepting edge. Done is expected four negedges later.
    task automatic start(input logic [79:0] f, input logic [1:0] rm,
                         input logic [63:0] m, input logic s, input logic iv, input logic p);
        fp_in      = f;
        round_mode = rm;
        enable     = 1'b1;
        sb.push_back('{mag: m, sign: s, inv: iv, prec: p, due: ncyc + 4});
        tick();
        enable = 1'b0;
    endtask

    task automatic run(input logic [79:0] f, input logic [1:0] rm,
                       input logic [63:0] m, input logic s, input logic iv, input logic p);
        tick();
        start(f, rm, m, s, iv, p);
        repeat (4) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        fp_in      = '0;
        round_mode = 2'b00;
        repeat (2) tick();
        chk("rst_uint",  uint_out, 64'h0);
        chk("rst_flags", {58'h0, sign_out, invalid, precision, busy, done, 1'b0}, 64'h0);
        reset = 1'b0;
        tick();

        //    operand                        RC     uint                   s  inv prec
        run(80'h3FFF_8000000000000000, 2'b00, 64'h1,                 0, 0, 0); // 1.0
        run(80'h4000_A000000000000000, 2'b00, 64'h2,                 0, 0, 1); // 2.5 ties to even
        run(80'h4000_E000000000000000, 2'b00, 64'h4,                 0, 0, 1); // 3.5 ties to even
        run(80'h4000_E000000000000000, 2'b11, 64'h3,                 0, 0, 1); // 3.5 truncate
        run(80'hC000_A000000000000000, 2'b00, 64'h2,                 1, 0, 1); // -2.5
        run(80'hBFFD_9999999999999999, 2'b10, 64'h0,                 1, 0, 1); // -0.3 up
        run(80'hBFFD_9999999999999999, 2'b01, 64'h1,                 1, 0, 1); // -0.3 down
        run(80'h3FFE_8000000000000000, 2'b00, 64'h0,                 0, 0, 1); // 0.5 ties to 0
        run(80'h3FFE_8000000000000000, 2'b10, 64'h1,                 0, 0, 1); // 0.5 up
        run(80'h0000_0000000000000001, 2'b10, 64'h1,                 0, 0, 1); // denormal up
        run(80'h403E_FFFFFFFFFFFFFFFF, 2'b00, 64'hFFFFFFFFFFFFFFFF,  0, 0, 0); // 2^64-1
        run(80'h403D_FFFFFFFFFFFFFFFF, 2'b00, 64'h8000000000000000,  0, 0, 1); // rounds up to 2^63
        run(80'h403F_8000000000000000, 2'b00, 64'h0,                 1, 1, 0); // 2^64
        run(80'h7FFF_8000000000000000, 2'b00, 64'h0,                 1, 1, 0); // +Inf
        run(80'h7FFF_C000000000000000, 2'b00, 64'h0,                 1, 1, 0); // QNaN
        run(80'h4000_4000000000000000, 2'b00, 64'h0,                 1, 1, 0); // unnormal
        run(80'h0000_0000000000000000, 2'b00, 64'h0,                 0, 0, 0); // +0
        run(80'h8000_0000000000000000, 2'b00, 64'h0,                 1, 0, 0); // -0

        // Back-to-back: second start lands in the done cycle of the first.
        tick();
        start(80'h4000_E000000000000000, 2'b00, 64'h4, 0, 0, 1);
        repeat (3) tick();
        start(80'h3FFF_8000000000000000, 2'b00, 64'h1, 0, 0, 0);
        repeat (4) tick();

        // enable held and fp_in changed while busy: only the first start counts.
        tick();
        start(80'h4001_A000000000000000, 2'b11, 64'h5, 0, 0, 0); // 5.0
        fp_in  = 80'h7FFF_8000000000000000;
        enable = 1'b1;
        repeat (3) tick();
        enable = 1'b0;
        repeat (6) tick();

        // Reset one cycle into a conversion: outputs clear and no done appears.
        run(80'h4000_E000000000000000, 2'b00, 64'h4, 0, 0, 1);
        tick();
        fp_in      = 80'h403E_FFFFFFFFFFFFFFFF;
        round_mode = 2'b00;
        enable     = 1'b1;
        tick();
        enable = 1'b0;
        reset  = 1'b1;
        tick();
        chk("abort_uint",  uint_out, 64'h0);
        chk("abort_flags", {58'h0, sign_out, invalid, precision, busy, done, 1'b0}, 64'h0);
        reset = 1'b0;
        repeat (6) tick();
        chk("abort_uint_held", uint_out, 64'h0);

        chk("sb_drained", 64'(sb.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
